// File: rtl/sram_like_arbiter.sv
`default_nettype none
// ============================================================================
// sram_like_arbiter: shares one SRAM-like slave between IF and MEM requesters,
// steering in-order responses via an owner FIFO. Optional macro: ARB_RR_EN.
// Revision: 1.0
// ============================================================================
module sram_like_arbiter #(
  parameter int OUTSTANDING = 4,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              inst_req,
  input  logic              inst_wr,
  input  logic [1:0]        inst_size,
  input  logic [3:0]        inst_wstrb,
  input  logic [ADDR_W-1:0] inst_addr,
  input  logic [DATA_W-1:0] inst_wdata,
  output logic              inst_addr_ok,
  output logic              inst_data_ok,
  output logic [DATA_W-1:0] inst_rdata,
  input  logic              data_req,
  input  logic              data_wr,
  input  logic [1:0]        data_size,
  input  logic [3:0]        data_wstrb,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [DATA_W-1:0] data_wdata,
  output logic              data_addr_ok,
  output logic              data_data_ok,
  output logic [DATA_W-1:0] data_rdata,
  output logic              slv_req,
  output logic              slv_wr,
  output logic [1:0]        slv_size,
  output logic [3:0]        slv_wstrb,
  output logic [ADDR_W-1:0] slv_addr,
  output logic [DATA_W-1:0] slv_wdata,
  input  logic              slv_addr_ok,
  input  logic              slv_data_ok,
  input  logic [DATA_W-1:0] slv_rdata
);
  localparam int PTR_W = $clog2(OUTSTANDING);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOCK_I = 2'd1,
    LOCK_D = 2'd2
  } state_t;

  state_t                 state, state_nxt;
  logic [OUTSTANDING-1:0] owner_q;
  logic [PTR_W-1:0]       head, tail;
  logic [CNT_W-1:0]       count;
  logic                   full, grant_vld, grant_d, accept, pop, head_owner, both_pick;

  assign full = (count == CNT_W'(OUTSTANDING));

`ifdef ARB_RR_EN
  // rr_prio=1 means data is preferred on a tie (inst was accepted last)
  logic rr_prio;
  always_ff @(posedge clk) begin
    if (!resetn)     rr_prio <= 1'b0;
    else if (accept) rr_prio <= ~grant_d;
  end
  assign both_pick = rr_prio;
`else
  assign both_pick = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    grant_vld = 1'b0;
    grant_d   = 1'b0;
    if (resetn && !full) begin
      case (state)
        IDLE: begin
          grant_vld = inst_req | data_req;
          grant_d   = data_req & (~inst_req | both_pick);
          if (grant_vld && !slv_addr_ok) state_nxt = grant_d ? LOCK_D : LOCK_I;
        end
        LOCK_I: begin
          grant_vld = 1'b1;
          if (slv_addr_ok) state_nxt = IDLE;
        end
        LOCK_D: begin
          grant_vld = 1'b1;
          grant_d   = 1'b1;
          if (slv_addr_ok) state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  assign accept     = grant_vld & slv_addr_ok;
  assign pop        = resetn & slv_data_ok & (count != '0);
  assign head_owner = owner_q[head];

  assign slv_req   = grant_vld;
  assign slv_wr    = grant_vld & (grant_d ? data_wr : inst_wr);
  assign slv_size  = grant_vld ? (grant_d ? data_size  : inst_size)  : 2'b0;
  assign slv_wstrb = grant_vld ? (grant_d ? data_wstrb : inst_wstrb) : 4'b0;
  assign slv_addr  = grant_vld ? (grant_d ? data_addr  : inst_addr)  : '0;
  assign slv_wdata = grant_vld ? (grant_d ? data_wdata : inst_wdata) : '0;

  assign inst_addr_ok = accept & ~grant_d;
  assign data_addr_ok = accept &  grant_d;
  assign inst_data_ok = pop & ~head_owner;
  assign data_data_ok = pop &  head_owner;
  assign inst_rdata   = inst_data_ok ? slv_rdata : '0;
  assign data_rdata   = data_data_ok ? slv_rdata : '0;

  // Owner FIFO: 0 = inst, 1 = data; pointers wrap naturally (power-of-2 depth)
  always_ff @(posedge clk) begin
    if (!resetn) begin
      owner_q <= '0;
      head    <= '0;
      tail    <= '0;
      count   <= '0;
    end else begin
      if (accept) begin
        owner_q[tail] <= grant_d;
        tail          <= tail + 1'b1;
      end
      if (pop) head <= head + 1'b1;
      if (accept && !pop)      count <= count + 1'b1;
      else if (pop && !accept) count <= count - 1'b1;
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_sram_like_arbiter.sv
`default_nettype none
// Bench for sram_like_arbiter: directed scenarios plus randomized traffic
// checked against a queue-based reference model.
module tb_sram_like_arbiter;
  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;

  logic clk = 1'b0, resetn = 1'b0;
  logic inst_req, inst_wr, data_req, data_wr, slv_addr_ok, slv_data_ok;
  logic [1:0] inst_size, data_size;
  logic [3:0] inst_wstrb, data_wstrb;
  logic [AW-1:0] inst_addr, data_addr;
  logic [DW-1:0] inst_wdata, data_wdata, slv_rdata;
  logic inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
  logic [DW-1:0] inst_rdata, data_rdata;
  logic slv_req, slv_wr;
  logic [1:0] slv_size;
  logic [3:0] slv_wstrb;
  logic [AW-1:0] slv_addr;
  logic [DW-1:0] slv_wdata;

  int n_cmp = 0, n_err = 0;

  sram_like_arbiter #(.OUTSTANDING(N), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .resetn(resetn),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size), .inst_wstrb(inst_wstrb),
    .inst_addr(inst_addr), .inst_wdata(inst_wdata), .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_wstrb(data_wstrb),
    .data_addr(data_addr), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
    .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .slv_req(slv_req), .slv_wr(slv_wr), .slv_size(slv_size), .slv_wstrb(slv_wstrb),
    .slv_addr(slv_addr), .slv_wdata(slv_wdata), .slv_addr_ok(slv_addr_ok),
    .slv_data_ok(slv_data_ok), .slv_rdata(slv_rdata)
  );

  always #5 clk = ~clk;

  logic [139:0] obs;
  assign obs = {slv_req, slv_wr, slv_size, slv_wstrb, slv_addr, slv_wdata,
                inst_addr_ok, inst_data_ok, inst_rdata, data_addr_ok, data_data_ok, data_rdata};

  // Reference model: owner queue, pending locked requester, tie preference
  bit mq[$];
  int lock = -1;
  bit prio = 1'b0;
  bit e_act, e_win, e_accept, e_pop, e_own;
  logic [139:0] e_vec;

  task automatic model_eval();
    logic [71:0] f;
    e_act = 0; e_win = 0; e_accept = 0; e_pop = 0; e_own = 0;
    if (resetn) begin
      if (mq.size() < N) begin
        if (lock >= 0) begin e_act = 1; e_win = (lock == 1); end
        else if (inst_req && data_req) begin
          e_act = 1;
`ifdef ARB_RR_EN
          e_win = prio;
`else
          e_win = 1;
`endif
        end else if (inst_req || data_req) begin e_act = 1; e_win = data_req; end
      end
      e_accept = e_act && slv_addr_ok;
      if (slv_data_ok && mq.size() > 0) begin e_pop = 1; e_own = mq[0]; end
    end
    f = '0;
    if (e_act)
      f = e_win ? {1'b1, data_wr, data_size, data_wstrb, data_addr, data_wdata}
                : {1'b1, inst_wr, inst_size, inst_wstrb, inst_addr, inst_wdata};
    e_vec = {f, e_accept && !e_win, e_pop && !e_own, (e_pop && !e_own) ? slv_rdata : 32'h0,
             e_accept && e_win, e_pop && e_own, (e_pop && e_own) ? slv_rdata : 32'h0};
  endtask

  task automatic model_advance();
    if (!resetn) begin
      mq.delete(); lock = -1; prio = 0;
    end else begin
      if (e_pop) void'(mq.pop_front());
      if (e_accept) begin mq.push_back(e_win); lock = -1; prio = !e_win; end
      else if (e_act) lock = e_win ? 1 : 0;
    end
  endtask

  task automatic clear_inputs();
    inst_req = 0; inst_wr = 0; inst_size = 0; inst_wstrb = 0; inst_addr = 0; inst_wdata = 0;
    data_req = 0; data_wr = 0; data_size = 0; data_wstrb = 0; data_addr = 0; data_wdata = 0;
    slv_addr_ok = 0; slv_data_ok = 0; slv_rdata = 0;
  endtask

  task automatic settle(); #4; model_eval(); endtask
  task automatic tick();   model_eval(); @(posedge clk); model_advance(); #1; endtask

  task automatic apply_reset();
    resetn = 0; clear_inputs(); settle(); tick(); resetn = 1;
  endtask

  task automatic drain();
    clear_inputs(); slv_data_ok = 1;
    for (int i = 0; i < 2 * N && mq.size() > 0; i++) begin settle(); tick(); end
    clear_inputs();
  endtask

  task automatic test_reset();
    resetn = 0; clear_inputs();
    inst_req = 1; data_req = 1; slv_addr_ok = 1; slv_data_ok = 1; inst_addr = 32'h1234;
    settle();
    n_cmp++; if (slv_req !== 1'b0) begin n_err++; $display("FAIL rst_slv_req got %b want 0", slv_req); end
    n_cmp++; if ({inst_addr_ok, data_addr_ok} !== 2'b00) begin n_err++; $display("FAIL rst_addr_ok got %b want 00", {inst_addr_ok, data_addr_ok}); end
    n_cmp++; if ({inst_data_ok, data_data_ok} !== 2'b00) begin n_err++; $display("FAIL rst_data_ok got %b want 00", {inst_data_ok, data_data_ok}); end
    tick();
    resetn = 1; clear_inputs(); settle();
    n_cmp++; if (obs !== 140'h0) begin n_err++; $display("FAIL rst_idle_outputs got %h want 0", obs); end
    tick();
  endtask

  task automatic test_single_inst();
    apply_reset();
    inst_req = 1; inst_addr = 32'h1c000000; inst_size = 2; slv_addr_ok = 1; settle();
    n_cmp++; if (inst_addr_ok !== 1'b1) begin n_err++; $display("FAIL t1_addr_ok got %b want 1", inst_addr_ok); end
    n_cmp++; if (slv_addr !== 32'h1c000000) begin n_err++; $display("FAIL t1_slv_addr got %h want 1c000000", slv_addr); end
    tick(); clear_inputs(); settle();
    n_cmp++; if (inst_data_ok !== 1'b0) begin n_err++; $display("FAIL t1_early_data_ok got %b want 0", inst_data_ok); end
    tick(); slv_data_ok = 1; slv_rdata = 32'h02c00000; settle();
    n_cmp++; if (inst_data_ok !== 1'b1) begin n_err++; $display("FAIL t1_data_ok got %b want 1", inst_data_ok); end
    n_cmp++; if (inst_rdata !== 32'h02c00000) begin n_err++; $display("FAIL t1_rdata got %h want 02c00000", inst_rdata); end
    n_cmp++; if (data_data_ok !== 1'b0) begin n_err++; $display("FAIL t1_other_data_ok got %b want 0", data_data_ok); end
    tick(); clear_inputs();
  endtask

  task automatic test_simultaneous();
    logic [1:0] want;
    apply_reset();
    inst_req = 1; data_req = 1; inst_addr = 32'h100; data_addr = 32'h200; slv_addr_ok = 1;
    for (int k = 0; k < 4; k++) begin
      slv_data_ok = (k > 0); settle();
`ifdef ARB_RR_EN
      want = (k % 2 == 0) ? 2'b10 : 2'b01;
`else
      want = 2'b01;
`endif
      n_cmp++; if ({inst_addr_ok, data_addr_ok} !== want) begin n_err++; $display("FAIL t2_order[%0d] got %b want %b", k, {inst_addr_ok, data_addr_ok}, want); end
      tick();
    end
    data_req = 0; settle();
    n_cmp++; if ({inst_addr_ok, data_addr_ok} !== 2'b10) begin n_err++; $display("FAIL t2_inst_after got %b want 10", {inst_addr_ok, data_addr_ok}); end
    tick(); drain();
  endtask

  task automatic test_lock();
    apply_reset();
    inst_req = 1; inst_addr = 32'h1c000040; settle();
    n_cmp++; if ({slv_req, inst_addr_ok} !== 2'b10) begin n_err++; $display("FAIL t3_req got %b want 10", {slv_req, inst_addr_ok}); end
    tick();
    data_req = 1; data_addr = 32'h80000000;
    for (int k = 1; k < 3; k++) begin
      settle();
      n_cmp++; if (slv_addr !== 32'h1c000040 || data_addr_ok !== 1'b0) begin n_err++; $display("FAIL t3_lock[%0d] got addr %h dok %b want 1c000040 0", k, slv_addr, data_addr_ok); end
      tick();
    end
    slv_addr_ok = 1; settle();
    n_cmp++; if ({inst_addr_ok, data_addr_ok} !== 2'b10 || slv_addr !== 32'h1c000040) begin n_err++; $display("FAIL t3_accept got %b addr %h want 10 1c000040", {inst_addr_ok, data_addr_ok}, slv_addr); end
    tick(); inst_req = 0; settle();
    n_cmp++; if (data_addr_ok !== 1'b1 || slv_addr !== 32'h80000000) begin n_err++; $display("FAIL t3_data_next got %b addr %h want 1 80000000", data_addr_ok, slv_addr); end
    tick(); drain();
  endtask

  task automatic test_full();
    apply_reset();
    for (int k = 0; k < 4; k++) begin
      clear_inputs(); slv_addr_ok = 1;
      if (k % 2 == 0) begin inst_req = 1; inst_addr = k; end else begin data_req = 1; data_addr = k; end
      settle();
      n_cmp++; if ({inst_addr_ok, data_addr_ok} !== ((k % 2 == 0) ? 2'b10 : 2'b01)) begin n_err++; $display("FAIL t4_fill[%0d] got %b", k, {inst_addr_ok, data_addr_ok}); end
      tick();
    end
    clear_inputs(); inst_req = 1; slv_addr_ok = 1; settle();
    n_cmp++; if ({slv_req, inst_addr_ok} !== 2'b00) begin n_err++; $display("FAIL t4_full_block got %b want 00", {slv_req, inst_addr_ok}); end
    tick(); slv_data_ok = 1; slv_rdata = 32'h1000; settle();
    n_cmp++; if ({slv_req, inst_data_ok, data_data_ok} !== 3'b010 || inst_rdata !== 32'h1000) begin n_err++; $display("FAIL t4_pop_full got %b rdata %h want 010 1000", {slv_req, inst_data_ok, data_data_ok}, inst_rdata); end
    tick(); slv_rdata = 32'h1001; settle();
    n_cmp++; if ({inst_addr_ok, inst_data_ok, data_data_ok} !== 3'b101 || data_rdata !== 32'h1001) begin n_err++; $display("FAIL t4_push_pop got %b rdata %h want 101 1001", {inst_addr_ok, inst_data_ok, data_data_ok}, data_rdata); end
    tick(); inst_req = 0; slv_addr_ok = 0;
    for (int j = 0; j < 3; j++) begin
      slv_rdata = 32'h1002 + j; settle();
      n_cmp++; if ({inst_data_ok, data_data_ok} !== ((j % 2 == 1) ? 2'b01 : 2'b10) || (inst_rdata | data_rdata) !== 32'h1002 + j) begin n_err++; $display("FAIL t4_route[%0d] got %b i %h d %h", j, {inst_data_ok, data_data_ok}, inst_rdata, data_rdata); end
      tick();
    end
    settle();
    n_cmp++; if ({inst_data_ok, data_data_ok} !== 2'b00) begin n_err++; $display("FAIL t4_empty_drop got %b want 00", {inst_data_ok, data_data_ok}); end
    tick(); clear_inputs();
  endtask

  task automatic test_reset_mid();
    apply_reset();
    inst_req = 1; slv_addr_ok = 1; settle(); tick();
    inst_req = 0; data_req = 1; settle(); tick();
    resetn = 0; clear_inputs(); inst_req = 1; settle();
    n_cmp++; if (slv_req !== 1'b0) begin n_err++; $display("FAIL t5_rst_req got %b want 0", slv_req); end
    tick(); resetn = 1; clear_inputs();
    for (int k = 0; k < 2; k++) begin
      slv_data_ok = 1; slv_rdata = 32'hbad0 + k; settle();
      n_cmp++; if ({inst_data_ok, data_data_ok} !== 2'b00) begin n_err++; $display("FAIL t5_stale[%0d] got %b want 00", k, {inst_data_ok, data_data_ok}); end
      tick();
    end
    clear_inputs(); inst_req = 1; inst_addr = 32'h1c000100; slv_addr_ok = 1; settle();
    n_cmp++; if (inst_addr_ok !== 1'b1) begin n_err++; $display("FAIL t5_new_accept got %b want 1", inst_addr_ok); end
    tick(); clear_inputs(); slv_data_ok = 1; slv_rdata = 32'h55; settle();
    n_cmp++; if (inst_data_ok !== 1'b1 || inst_rdata !== 32'h55) begin n_err++; $display("FAIL t5_new_resp got %b %h want 1 55", inst_data_ok, inst_rdata); end
    tick(); clear_inputs();
  endtask

  task automatic test_write();
    apply_reset();
    data_req = 1; data_wr = 1; data_size = 2; data_wstrb = 4'hf; data_wdata = 32'hdeadbeef;
    data_addr = 32'h1fc00010; slv_addr_ok = 1; settle();
    n_cmp++; if ({slv_req, slv_wr, slv_size, slv_wstrb} !== 8'b1110_1111) begin n_err++; $display("FAIL t6_ctrl got %b want 11101111", {slv_req, slv_wr, slv_size, slv_wstrb}); end
    n_cmp++; if (slv_wdata !== 32'hdeadbeef || slv_addr !== 32'h1fc00010) begin n_err++; $display("FAIL t6_fields got %h %h want deadbeef 1fc00010", slv_wdata, slv_addr); end
    n_cmp++; if (data_addr_ok !== 1'b1) begin n_err++; $display("FAIL t6_addr_ok got %b want 1", data_addr_ok); end
    tick(); clear_inputs(); slv_data_ok = 1; settle();
    n_cmp++; if ({inst_data_ok, data_data_ok} !== 2'b01) begin n_err++; $display("FAIL t6_resp got %b want 01", {inst_data_ok, data_data_ok}); end
    tick(); clear_inputs();
  endtask

  task automatic test_random();
    apply_reset();
    for (int c = 0; c < 600; c++) begin
      if (!inst_req || (e_accept && !e_win)) begin
        inst_req = ($urandom % 2 == 0); inst_wr = $urandom; inst_size = $urandom % 3;
        inst_wstrb = $urandom; inst_addr = $urandom; inst_wdata = $urandom;
      end
      if (!data_req || (e_accept && e_win)) begin
        data_req = ($urandom % 2 == 0); data_wr = $urandom; data_size = $urandom % 3;
        data_wstrb = $urandom; data_addr = $urandom; data_wdata = $urandom;
      end
      slv_addr_ok = ($urandom % 3 != 0);
      slv_data_ok = ($urandom % 2 == 0);
      slv_rdata   = $urandom;
      resetn      = ($urandom % 64 != 0);
      settle();
      n_cmp++; if (obs !== e_vec) begin n_err++; $display("FAIL rand[%0d] got %h want %h", c, obs, e_vec); end
      tick();
    end
    resetn = 1; clear_inputs();
  endtask

  initial begin
    clear_inputs();
    @(posedge clk); #1;
    test_reset();
    test_single_inst();
    test_simultaneous();
    test_lock();
    test_full();
    test_reset_mid();
    test_write();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
`default_nettype wire
